dynamic_preadd_macc: RTL and testbench
======================================

Name: dynamic_preadd_macc

Overview:
Pipelined signed pre-adder/multiplier/accumulator computing P = acc_en ? P + (A ± D)*B : (A ± D)*B.
- Add/subtract and accumulate/load are selected per sample.
- Next generation of the dynamic pre-add multiplier: adds a valid handshake, a wide accumulator, and a sticky overflow flag.
- Sits in the DSP datapath (FIR taps, dot products); maps onto one DSP48-style slice.

Parameters:
- AW, 16: width of ain/din (signed)
- BW, 16: width of bin (signed)
- ACCW, 48: accumulator/pout width (signed); elaboration error if ACCW < AW+1+BW

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; 0 freezes every pipeline register, including valids
- in_valid  in  1  input beat valid
- subadd  in  1  0: A+D, 1: A-D (sampled with beat)
- acc_en  in  1  1: accumulate onto P, 0: load P with the product (sampled with beat)
- ain  in  AW  signed A
- din  in  AW  signed D
- bin  in  BW  signed B
- out_valid  out  1  pout updated by a beat this cycle
- pout  out  ACCW  signed accumulator
- ovf  out  1  sticky signed-overflow flag

Behaviour:
- Reset: all stage registers, out_valid, pout and ovf go to 0 asynchronously. A mid-pipeline reset discards in-flight beats and emits no out_valid afterwards.
- Pipeline advances only when ce=1. With ce=0, all state holds and out_valid holds its last value.
- S1: register ain, din, bin, subadd, acc_en, in_valid.
- S2: pre = subadd ? a-d : a+d at width AW+1, sign-extended, never overflows. b and control are delayed alongside.
- S3: m = pre*b at width MW=AW+1+BW, full precision, never overflows.
- S4 (valid beat only):
  - acc_en=1: pout <= pout + sext(m)
  - acc_en=0: pout <= sext(m), and ovf clears before this beat's evaluation.
- S4 (invalid beat): pout holds.
- Latency: 4 ce-enabled cycles from in_valid to out_valid. Throughput is one beat per ce cycle.
- out_valid = S4 valid register; it is a 1-cycle pulse per beat when ce is continuous.
- Overflow: on an accumulate beat, detect signed overflow when both operands have the same sign and the result sign differs. On detection, ovf <= 1 and it stays set until the next load beat or reset.
- Default arithmetic: two's-complement wrap.
- Invalid beats carry don't-care data but must not alter pout or ovf.
- Simultaneous load beat that itself overflows: impossible, since ACCW >= MW.

Optional Feature:
- Macro: DYNAMIC_PREADD_MACC_SAT_EN.
- Defined: on overflow, pout saturates to +2^(ACCW-1)-1 (positive overflow) or -2^(ACCW-1) (negative overflow). ovf is still set. Later beats accumulate from the saturated value.
- Undefined: pout wraps; no saturation logic is generated.

Decomposition:
- Package dynamic_preadd_pkg:
  - typedef struct packed {logic subadd; logic acc_en;} op_t
  - localparam function mw(aw, bw) returning aw+1+bw
  - function sat_add(a, b) returning {sum, ovf}, used under the macro
- Sub-module preadd_mult_core: stages S1–S3, with ce and valid/op passthrough. Reusable by the existing non-accumulating multiplier.
- Accumulator and ovf logic stay in the top module.

Test Plan:
- Reset, then ce=1 with one beat: a=3, d=2, b=4, subadd=0, acc_en=0 -> 4 cycles later out_valid=1, pout=20, ovf=0.
- Back-to-back beats: (3,2,4,add,load), (1,5,-3,sub,acc), (-7,-3,2,add,acc) -> pout sequence 20, 32, 12 on consecutive cycles.
- ce=0 held for 3 cycles after the second beat -> pout, out_valid and stage contents frozen; outputs resume unchanged afterwards; total latency is 4+3 cycles.
- Extremes, ACCW=48: a=d=-32768, add, b=-32768, load -> pout=2147483648, no overflow, no truncation.
- ACCW=34 override: load 2147483648, then 3 accumulates of the same -> the 4th sum 8589934592 overflows:
  - without macro: pout=-8589934592, ovf=1
  - with macro: pout=8589934591, ovf=1
  - the next load beat clears ovf.
- Assert rst_n low with 2 beats in flight -> pout=0, ovf=0, out_valid=0 immediately; no out_valid appears after release.

Source files
------------

// File: rtl/dynamic_preadd_pkg.sv
// Shared types and helpers for the dynamic pre-add multiply-accumulate slice.
//   op_t      : per-beat control (subadd: 0 A+D / 1 A-D, acc_en: 1 accumulate / 0 load)
//   mw()      : full-precision product width for given A and B widths
//   sat_add() : signed add at a run-time width w (<= SAT_W) that returns the
//               saturated sum and the overflow flag; operands must already be
//               sign-extended to SAT_W bits.
package dynamic_preadd_pkg;

  typedef struct packed {
    logic subadd;
    logic acc_en;
  } op_t;

  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] sum;
    logic             ovf;
  } sat_res_t;

  function automatic int unsigned mw(input int unsigned aw, input int unsigned bw);
    return aw + 1 + bw;
  endfunction

  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b,
                                       input int unsigned      w);
    sat_res_t         r;
    logic [SAT_W-1:0] max_v;
    logic [5:0]       msb;
    msb   = 6'(w - 1);
    r.sum = a + b;
    r.ovf = (a[msb] == b[msb]) && (r.sum[msb] != a[msb]);
    max_v = (SAT_W'(1) << msb) - SAT_W'(1);
    // ~max_v is -2^(w-1) already sign-extended to SAT_W bits
    if (r.ovf) r.sum = a[msb] ? ~max_v : max_v;
    return r;
  endfunction

endpackage

// File: rtl/preadd_mult_core.sv
// Three-stage signed pre-adder / multiplier (S1 input regs, S2 pre-add, S3 multiply).
// Ports:
//   clk, rst_n (async active-low), ce (freezes all stages incl. valids)
//   in_valid, in_op, ain, din, bin : input beat
//   out_valid, out_op, mout        : S3 valid, delayed control, full-precision (A+-D)*B
module preadd_mult_core
  import dynamic_preadd_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned BW = 16,
  localparam int unsigned MW = mw(AW, BW)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  op_t                  in_op,
  input  logic signed [AW-1:0] ain,
  input  logic signed [AW-1:0] din,
  input  logic signed [BW-1:0] bin,
  output logic                 out_valid,
  output op_t                  out_op,
  output logic signed [MW-1:0] mout
);

  logic signed [AW-1:0] a1_q, a1_d, d1_q, d1_d;
  logic signed [BW-1:0] b1_q, b1_d, b2_q, b2_d;
  logic signed [AW:0]   pre2_q, pre2_d;
  logic signed [MW-1:0] m3_q, m3_d;
  op_t                  op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  always_comb begin
    a1_d   = a1_q;
    d1_d   = d1_q;
    b1_d   = b1_q;
    op1_d  = op1_q;
    v1_d   = v1_q;
    pre2_d = pre2_q;
    b2_d   = b2_q;
    op2_d  = op2_q;
    v2_d   = v2_q;
    m3_d   = m3_q;
    op3_d  = op3_q;
    v3_d   = v3_q;
    if (ce) begin
      a1_d   = ain;
      d1_d   = din;
      b1_d   = bin;
      op1_d  = in_op;
      v1_d   = in_valid;
      pre2_d = op1_q.subadd ? ((AW+1)'(a1_q) - (AW+1)'(d1_q))
                            : ((AW+1)'(a1_q) + (AW+1)'(d1_q));
      b2_d   = b1_q;
      op2_d  = op1_q;
      v2_d   = v1_q;
      m3_d   = MW'(pre2_q) * MW'(b2_q);
      op3_d  = op2_q;
      v3_d   = v2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q   <= '0;
      d1_q   <= '0;
      b1_q   <= '0;
      op1_q  <= '0;
      v1_q   <= 1'b0;
      pre2_q <= '0;
      b2_q   <= '0;
      op2_q  <= '0;
      v2_q   <= 1'b0;
      m3_q   <= '0;
      op3_q  <= '0;
      v3_q   <= 1'b0;
    end else begin
      a1_q   <= a1_d;
      d1_q   <= d1_d;
      b1_q   <= b1_d;
      op1_q  <= op1_d;
      v1_q   <= v1_d;
      pre2_q <= pre2_d;
      b2_q   <= b2_d;
      op2_q  <= op2_d;
      v2_q   <= v2_d;
      m3_q   <= m3_d;
      op3_q  <= op3_d;
      v3_q   <= v3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_op    = op3_q;
  assign mout      = m3_q;

endmodule

// File: rtl/dynamic_preadd_macc.sv
// Pipelined signed pre-add multiply-accumulate:
//   P = acc_en ? P + (A +- D)*B : (A +- D)*B, 4 ce-enabled cycles latency.
// Ports:
//   clk, rst_n (async active-low), ce (freezes every pipeline register)
//   in_valid, subadd, acc_en, ain, din, bin : input beat
//   out_valid : pout updated by a beat this cycle
//   pout      : ACCW-bit signed accumulator
//   ovf       : sticky signed overflow, cleared by a load beat or reset
// Build option: define DYNAMIC_PREADD_MACC_SAT_EN to saturate pout on overflow
// instead of wrapping (requires ACCW <= 64).
module dynamic_preadd_macc
  import dynamic_preadd_pkg::*;
#(
  parameter int unsigned AW   = 16,
  parameter int unsigned BW   = 16,
  parameter int unsigned ACCW = 48
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic                   subadd,
  input  logic                   acc_en,
  input  logic signed [AW-1:0]   ain,
  input  logic signed [AW-1:0]   din,
  input  logic signed [BW-1:0]   bin,
  output logic                   out_valid,
  output logic signed [ACCW-1:0] pout,
  output logic                   ovf
);

  localparam int unsigned MW = mw(AW, BW);

  if (ACCW < MW) begin : g_accw_chk
    $error("dynamic_preadd_macc: ACCW must be >= AW+1+BW");
  end

  op_t                    in_op;
  op_t                    s3_op;
  logic                   s3_valid;
  logic signed [MW-1:0]   s3_m;
  logic signed [ACCW-1:0] m_ext;
  logic signed [ACCW-1:0] acc_sum;
  logic                   acc_ovf;

  logic signed [ACCW-1:0] pout_q, pout_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;

  assign in_op = '{subadd: subadd, acc_en: acc_en};

  preadd_mult_core #(
    .AW (AW),
    .BW (BW)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_op     (in_op),
    .ain       (ain),
    .din       (din),
    .bin       (bin),
    .out_valid (s3_valid),
    .out_op    (s3_op),
    .mout      (s3_m)
  );

  assign m_ext = ACCW'(s3_m);

`ifdef DYNAMIC_PREADD_MACC_SAT_EN
  if (ACCW > SAT_W) begin : g_sat_chk
    $error("dynamic_preadd_macc: saturation supports ACCW <= 64");
  end

  sat_res_t acc_res;
  assign acc_res = sat_add(SAT_W'(pout_q), SAT_W'(m_ext), ACCW);
  assign acc_sum = acc_res.sum[ACCW-1:0];
  assign acc_ovf = acc_res.ovf;
`else
  assign acc_sum = pout_q + m_ext;
  // same-sign operands whose sum flips sign
  assign acc_ovf = (pout_q[ACCW-1] == m_ext[ACCW-1]) &&
                   (acc_sum[ACCW-1] != pout_q[ACCW-1]);
`endif

  always_comb begin
    pout_d      = pout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (ce) begin
      out_valid_d = s3_valid;
      if (s3_valid) begin
        if (s3_op.acc_en) begin
          pout_d = acc_sum;
          ovf_d  = ovf_q | acc_ovf;
        end else begin
          // a load can never overflow since ACCW >= MW; it restarts the sticky flag
          pout_d = m_ext;
          ovf_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout_q      <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      pout_q      <= pout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pout      = pout_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dynamic_preadd_macc.sv
// Scoreboard bench for dynamic_preadd_macc: one ACCW=48 instance and one
// ACCW=34 instance sharing data inputs, each with its own in_valid.
module tb_dynamic_preadd_macc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n, ce, in_valid48, in_valid34, subadd, acc_en;
  logic signed [15:0]  ain, din, bin;
  logic                out_valid48, ovf48, out_valid34, ovf34;
  logic signed [47:0]  pout48;
  logic signed [33:0]  pout34;

  dynamic_preadd_macc #(.AW(16), .BW(16), .ACCW(48)) u_dut48 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid48),
    .subadd(subadd), .acc_en(acc_en), .ain(ain), .din(din), .bin(bin),
    .out_valid(out_valid48), .pout(pout48), .ovf(ovf48)
  );

  dynamic_preadd_macc #(.AW(16), .BW(16), .ACCW(34)) u_dut34 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid34),
    .subadd(subadd), .acc_en(acc_en), .ain(ain), .din(din), .bin(bin),
    .out_valid(out_valid34), .pout(pout34), .ovf(ovf34)
  );

  typedef struct {
    logic signed [47:0] pout;
    logic               ovf;
    int                 cyc;
  } exp_t;

  exp_t q48[$];
  exp_t q34[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic ce_q  = 1'b0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    ce_q <= ce;
  end

  task automatic check(input string name, input logic signed [47:0] act,
                       input logic signed [47:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0b, required %0b", name, act, req);
    end
  endtask

  task automatic pop_check(input int sel, input logic signed [47:0] p, input logic o);
    exp_t e;
    if ((sel == 0 && q48.size() == 0) || (sel == 1 && q34.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL unexpected_out_valid dut%0d: got pout %0d, required no output", sel, p);
      return;
    end
    if (sel == 0) e = q48.pop_front();
    else          e = q34.pop_front();
    check((sel == 0) ? "pout48" : "pout34", p, e.pout);
    check1((sel == 0) ? "ovf48" : "ovf34", o, e.ovf);
    check((sel == 0) ? "latency48" : "latency34", 48'(cyc), 48'(e.cyc));
  endtask

  // Monitor: only count out_valid that follows a ce-enabled edge (held values are stale).
  always @(negedge clk) begin
    if (ce_q) begin
      if (out_valid48) pop_check(0, pout48, ovf48);
      if (out_valid34) pop_check(1, 48'(pout34), ovf34);
    end
  end

  task automatic beat(input int sel, input int a, input int d, input int b,
                      input logic sub, input logic acc,
                      input logic signed [47:0] ep, input logic eo,
                      input int stall_cycles, input bit push);
    exp_t e;
    ain        = a[15:0];
    din        = d[15:0];
    bin        = b[15:0];
    subadd     = sub;
    acc_en     = acc;
    in_valid48 = (sel == 0);
    in_valid34 = (sel == 1);
    if (push) begin
      e.pout = ep;
      e.ovf  = eo;
      e.cyc  = cyc + 4 + stall_cycles;
      if (sel == 0) q48.push_back(e);
      else          q34.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid48 = 1'b0;
    in_valid34 = 1'b0;
    for (int i = 0; i < n; i++) begin
      ain    = 16'($urandom);
      din    = 16'($urandom);
      bin    = 16'($urandom);
      subadd = 1'($urandom);
      acc_en = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic stall(input int n);
    logic signed [47:0] p;
    logic               v;
    in_valid48 = 1'b0;
    in_valid34 = 1'b0;
    ce         = 1'b0;
    p          = pout48;
    v          = out_valid48;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("stall_pout48", pout48, p);
      check1("stall_valid48", out_valid48, v);
    end
    ce = 1'b1;
  endtask

`ifdef DYNAMIC_PREADD_MACC_SAT_EN
  localparam logic signed [47:0] OVF4 = 48'sd8589934591;
  localparam logic signed [47:0] OVF5 = 48'sd8589934591;
`else
  localparam logic signed [47:0] OVF4 = -48'sd8589934592;
  localparam logic signed [47:0] OVF5 = -48'sd8589934572;
`endif

  initial begin
    rst_n      = 1'b0;
    ce         = 1'b1;
    in_valid48 = 1'b0;
    in_valid34 = 1'b0;
    subadd     = 1'b0;
    acc_en     = 1'b0;
    ain        = '0;
    din        = '0;
    bin        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pout48", pout48, 48'sd0);
    check1("rst_ovf48", ovf48, 1'b0);
    check1("rst_valid48", out_valid48, 1'b0);
    check("rst_pout34", 48'(pout34), 48'sd0);
    check1("rst_ovf34", ovf34, 1'b0);
    check1("rst_valid34", out_valid34, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single load beat: (3+2)*4
    beat(0, 3, 2, 4, 1'b0, 1'b0, 48'sd20, 1'b0, 0, 1'b1);
    idle(6);

    // back-to-back: load 20, +(1-5)*-3=+12 -> 32, +(-7-3)*2=-20 -> 12
    beat(0, 3, 2, 4, 1'b0, 1'b0, 48'sd20, 1'b0, 0, 1'b1);
    beat(0, 1, 5, -3, 1'b1, 1'b1, 48'sd32, 1'b0, 0, 1'b1);
    beat(0, -7, -3, 2, 1'b0, 1'b1, 48'sd12, 1'b0, 0, 1'b1);
    idle(6);

    // ce low for 3 cycles right after the second beat: both beats arrive 3 late
    beat(0, 3, 2, 4, 1'b0, 1'b0, 48'sd20, 1'b0, 3, 1'b1);
    beat(0, 1, 5, -3, 1'b1, 1'b1, 48'sd32, 1'b0, 3, 1'b1);
    stall(3);
    idle(8);

    // extremes: (-32768-32768)*-32768 = 2^31; then +(32767+32768)*-32768 -> 32768
    beat(0, -32768, -32768, -32768, 1'b0, 1'b0, 48'sd2147483648, 1'b0, 0, 1'b1);
    beat(0, 32767, -32768, -32768, 1'b1, 1'b1, 48'sd32768, 1'b0, 0, 1'b1);
    idle(6);

    // ACCW=34: 2^31 accumulated four times reaches 2^33 and overflows
    beat(1, -32768, -32768, -32768, 1'b0, 1'b0, 48'sd2147483648, 1'b0, 0, 1'b1);
    beat(1, -32768, -32768, -32768, 1'b0, 1'b1, 48'sd4294967296, 1'b0, 0, 1'b1);
    beat(1, -32768, -32768, -32768, 1'b0, 1'b1, 48'sd6442450944, 1'b0, 0, 1'b1);
    beat(1, -32768, -32768, -32768, 1'b0, 1'b1, OVF4, 1'b1, 0, 1'b1);
    beat(1, 3, 2, 4, 1'b0, 1'b1, OVF5, 1'b1, 0, 1'b1);
    beat(1, 3, 2, 4, 1'b0, 1'b0, 48'sd20, 1'b0, 0, 1'b1);
    idle(8);

    // reset with two beats in flight: outputs clear at once, nothing emerges later
    beat(0, 5, 1, 7, 1'b0, 1'b0, 48'sd0, 1'b0, 0, 1'b0);
    beat(0, 5, 1, 7, 1'b0, 1'b1, 48'sd0, 1'b0, 0, 1'b0);
    in_valid48 = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("midrst_pout48", pout48, 48'sd0);
    check1("midrst_ovf48", ovf48, 1'b0);
    check1("midrst_valid48", out_valid48, 1'b0);
    check("midrst_pout34", 48'(pout34), 48'sd0);
    check1("midrst_ovf34", ovf34, 1'b0);
    check1("midrst_valid34", out_valid34, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);

    check("drain_q48", 48'(q48.size()), 48'sd0);
    check("drain_q34", 48'(q34.size()), 48'sd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
